// File: rtl/imem_prog_if.sv
// Bus bundle for the writable instruction memory: streaming load port,
// flush, and the pc fetch port with its registered results.
interface imem_prog_if #(
  parameter int ADDR_W = 8,
  parameter int OP_W   = 32
);
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [ADDR_W:0]   load_len;
  logic              load_valid;
  logic [OP_W-1:0]   load_data;
  logic              load_ready;
  logic              load_done;
  logic              busy;
  logic              flush;
  logic              fetch_en;
  logic [ADDR_W-1:0] pc;
  logic [OP_W-1:0]   op;
  logic              op_valid;
  logic              fault;

  modport slave (
    input  load_start, load_base, load_len, load_valid, load_data,
    input  flush, fetch_en, pc,
    output load_ready, load_done, busy, op, op_valid, fault
  );

  modport master (
    output load_start, load_base, load_len, load_valid, load_data,
    output flush, fetch_en, pc,
    input  load_ready, load_done, busy, op, op_valid, fault
  );
endinterface

// File: rtl/imem_prog.sv
// Writable instruction memory: streaming burst loader with per-word valid
// bits, and a one-cycle registered fetch port that faults on unloaded words.
module imem_prog #(
  parameter int              ADDR_W  = 8,
  parameter int              OP_W    = 32,
  parameter int              DEPTH   = 256,
  parameter logic [OP_W-1:0] FILL_OP = {OP_W{1'b0}}
) (
  input logic        clk,
  input logic        rst,
  imem_prog_if.slave bus
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     DEPTH_U   = DEPTH;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [DEPTH-1:0]  vbit_q, vbit_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              op_valid_q, op_valid_d;
  logic              fault_q, fault_d;
  logic              load_ready_q, load_ready_d;
  logic              load_done_q, load_done_d;
  logic              busy_q, busy_d;

  logic [OP_W-1:0]   mem [DEPTH];

  logic              mem_we_s;
  logic              wr_in_range_s;
  logic              pc_in_range_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [IDX_W-1:0]  pc_idx_s;
  logic [OP_W-1:0]   rd_word_s;

  assign wr_in_range_s = (32'(wr_addr_q) < DEPTH_U);
  assign pc_in_range_s = (32'(bus.pc) < DEPTH_U);
  assign wr_idx_s      = wr_addr_q[IDX_W-1:0];
  assign pc_idx_s      = bus.pc[IDX_W-1:0];
  assign rd_word_s     = mem[pc_idx_s];

  assign bus.op         = op_q;
  assign bus.op_valid   = op_valid_q;
  assign bus.fault      = fault_q;
  assign bus.load_ready = load_ready_q;
  assign bus.load_done  = load_done_q;
  assign bus.busy       = busy_q;

  // Next-state: load sequencing, valid-bit tracking and fetch results.
  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    remaining_d  = remaining_q;
    vbit_d       = vbit_q;
    op_d         = op_q;
    op_valid_d   = 1'b0;
    fault_d      = 1'b0;
    load_ready_d = 1'b0;
    load_done_d  = 1'b0;
    busy_d       = 1'b0;
    mem_we_s     = 1'b0;

    case (state_q)
      IDLE, RUN: begin
        // flush takes priority over a simultaneous load request
        if (bus.flush) begin
          vbit_d  = {DEPTH{1'b0}};
          state_d = IDLE;
        end else if (bus.load_start && (bus.load_len != {(ADDR_W+1){1'b0}})) begin
          state_d      = LOAD;
          wr_addr_d    = bus.load_base;
          remaining_d  = bus.load_len;
          load_ready_d = 1'b1;
          busy_d       = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      LOAD: begin
        load_ready_d = 1'b1;
        busy_d       = 1'b1;
        if (bus.load_valid) begin
          mem_we_s    = wr_in_range_s;
          if (wr_in_range_s) begin
            vbit_d[wr_idx_s] = 1'b1;
          end else begin
            vbit_d = vbit_q;
          end
          remaining_d = remaining_q - {{ADDR_W{1'b0}}, 1'b1};
          if (wr_addr_q == LAST_ADDR) begin
            wr_addr_d = {ADDR_W{1'b0}};
          end else begin
            wr_addr_d = wr_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
          if (remaining_q == {{ADDR_W{1'b0}}, 1'b1}) begin
            state_d      = RUN;
            load_done_d  = 1'b1;
            load_ready_d = 1'b0;
            busy_d       = 1'b0;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Fetches only succeed in RUN, so reads never race the loader.
    if (bus.fetch_en) begin
      if (state_q == RUN) begin
        if (pc_in_range_s && vbit_q[pc_idx_s]) begin
          op_d       = rd_word_s;
          op_valid_d = 1'b1;
        end else begin
          op_d    = FILL_OP;
          fault_d = 1'b1;
        end
      end else begin
        fault_d = 1'b1;
      end
    end else begin
      op_d = op_q;
    end
  end

  // State, valid bits and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_addr_q    <= {ADDR_W{1'b0}};
      remaining_q  <= {(ADDR_W+1){1'b0}};
      vbit_q       <= {DEPTH{1'b0}};
      op_q         <= FILL_OP;
      op_valid_q   <= 1'b0;
      fault_q      <= 1'b0;
      load_ready_q <= 1'b0;
      load_done_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      remaining_q  <= remaining_d;
      vbit_q       <= vbit_d;
      op_q         <= op_d;
      op_valid_q   <= op_valid_d;
      fault_q      <= fault_d;
      load_ready_q <= load_ready_d;
      load_done_q  <= load_done_d;
      busy_q       <= busy_d;
    end
  end

  // Word storage; contents survive reset and are gated by the valid bits.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[wr_idx_s] <= bus.load_data;
    end
  end

endmodule

// File: tb/tb_imem_prog.sv
// Scoreboard bench for imem_prog: a reference model predicts each fetch
// result when the fetch is driven; results are popped one cycle later.
module tb_imem_prog;
  localparam int ADDR_W = 8;
  localparam int OP_W   = 32;
  localparam int DEPTH  = 256;
  localparam logic [31:0] FILL = 32'h0000_0000;

  typedef struct {
    logic [31:0] op;
    logic        v;
    logic        f;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_prog_if #(.ADDR_W(ADDR_W), .OP_W(OP_W)) bus_if ();

  imem_prog #(.ADDR_W(ADDR_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int          checks   = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  logic [31:0] m_mem [DEPTH];
  logic        m_v   [DEPTH];
  logic        m_run;
  logic [31:0] m_op;
  logic [31:0] wbuf  [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("op", bus_if.op, e.op);
      chk("op_valid", {31'd0, bus_if.op_valid}, {31'd0, e.v});
      chk("fault", {31'd0, bus_if.fault}, {31'd0, e.f});
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] p);
    exp_t e;
    bus_if.fetch_en = 1'b1;
    bus_if.pc       = p;
    if (m_run && m_v[p]) begin
      m_op = m_mem[p];
      e = '{m_mem[p], 1'b1, 1'b0};
    end else if (m_run) begin
      m_op = FILL;
      e = '{FILL, 1'b0, 1'b1};
    end else begin
      e = '{m_op, 1'b0, 1'b1};
    end
    exp_q.push_back(e);
    step();
    bus_if.fetch_en = 1'b0;
  endtask

  task automatic fetch_off();
    bus_if.fetch_en = 1'b0;
    exp_q.push_back('{m_op, 1'b0, 1'b0});
    step();
  endtask

  // Burst of len words from wbuf; one idle cycle after word index gap.
  task automatic load(input logic [7:0] base, input int len, input int gap);
    bus_if.load_start = 1'b1;
    bus_if.load_base  = base;
    bus_if.load_len   = 9'(len);
    step();
    bus_if.load_start = 1'b0;
    m_run = 1'b0;
    chk("busy_on", {31'd0, bus_if.busy}, 32'd1);
    chk("ready_on", {31'd0, bus_if.load_ready}, 32'd1);
    for (int i = 0; i < len; i++) begin
      bus_if.load_valid = 1'b1;
      bus_if.load_data  = wbuf[i];
      step();
      bus_if.load_valid = 1'b0;
      m_mem[(32'(base) + i) % DEPTH] = wbuf[i];
      m_v[(32'(base) + i) % DEPTH]   = 1'b1;
      if (i == len - 1) begin
        chk("done_pulse", {31'd0, bus_if.load_done}, 32'd1);
        chk("busy_off", {31'd0, bus_if.busy}, 32'd0);
        chk("ready_off", {31'd0, bus_if.load_ready}, 32'd0);
      end else begin
        chk("done_early", {31'd0, bus_if.load_done}, 32'd0);
      end
      if (i == gap) begin
        step();
        chk("done_gap", {31'd0, bus_if.load_done}, 32'd0);
        chk("ready_gap", {31'd0, bus_if.load_ready}, 32'd1);
      end
    end
    step();
    chk("done_once", {31'd0, bus_if.load_done}, 32'd0);
    m_run = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_if.load_start = 1'b0;
    bus_if.load_base  = 8'd0;
    bus_if.load_len   = 9'd0;
    bus_if.load_valid = 1'b0;
    bus_if.load_data  = 32'd0;
    bus_if.flush      = 1'b0;
    bus_if.fetch_en   = 1'b0;
    bus_if.pc         = 8'd0;
    model_clear();
    m_run = 1'b0;
    m_op  = FILL;

    // 1: reset values, fetch before any load
    repeat (2) @(posedge clk);
    #1;
    chk("rst_op", bus_if.op, FILL);
    chk("rst_op_valid", {31'd0, bus_if.op_valid}, 32'd0);
    chk("rst_fault", {31'd0, bus_if.fault}, 32'd0);
    chk("rst_ready", {31'd0, bus_if.load_ready}, 32'd0);
    chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    rst = 1'b0;
    step();
    fetch(8'd0);

    // 2: three-word burst with a gap, then consecutive fetches
    wbuf[0] = 32'h8600_0000; wbuf[1] = 32'hA000_0000; wbuf[2] = 32'h6000_0000;
    load(8'd0, 3, 0);
    fetch(8'd0); fetch(8'd1); fetch(8'd2);

    // 3: wrapping burst 254..1
    wbuf[0] = 32'h1111_1111; wbuf[1] = 32'h2222_2222;
    wbuf[2] = 32'h3333_3333; wbuf[3] = 32'h4444_4444;
    load(8'd254, 4, -1);
    fetch(8'd254); fetch(8'd255); fetch(8'd0); fetch(8'd1);
    fetch(8'd2); fetch(8'd3); fetch(8'd0);

    // 4: back-to-back fetches incl. self-jump, then idle holds op
    fetch(8'd5); fetch(8'd6); fetch(8'd0); fetch(8'd0); fetch(8'd254);
    fetch_off(); fetch_off();

    // zero-length load request is ignored
    bus_if.load_start = 1'b1;
    bus_if.load_len   = 9'd0;
    step();
    bus_if.load_start = 1'b0;
    chk("len0_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("len0_ready", {31'd0, bus_if.load_ready}, 32'd0);
    fetch(8'd1);

    // 5: flush beats load_start
    bus_if.flush      = 1'b1;
    bus_if.load_start = 1'b1;
    bus_if.load_base  = 8'd0;
    bus_if.load_len   = 9'd2;
    step();
    bus_if.flush      = 1'b0;
    bus_if.load_start = 1'b0;
    model_clear();
    m_run = 1'b0;
    chk("flush_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("flush_ready", {31'd0, bus_if.load_ready}, 32'd0);
    fetch(8'd0); fetch(8'd2);

    // 6: reset in mid-burst
    bus_if.load_start = 1'b1;
    bus_if.load_base  = 8'd10;
    bus_if.load_len   = 9'd5;
    step();
    bus_if.load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_if.load_valid = 1'b1;
      bus_if.load_data  = 32'hDEAD_0000 + 32'(i);
      step();
    end
    bus_if.load_valid = 1'b0;
    fetch(8'd10);
    rst = 1'b1;
    #1;
    model_clear();
    m_op = FILL;
    chk("mid_rst_ready", {31'd0, bus_if.load_ready}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("mid_rst_op", bus_if.op, FILL);
    step();
    rst = 1'b0;
    step();
    chk("mid_rst_done", {31'd0, bus_if.load_done}, 32'd0);
    chk("mid_rst_busy2", {31'd0, bus_if.busy}, 32'd0);
    wbuf[0] = 32'hC0DE_0007;
    load(8'd7, 1, -1);
    fetch(8'd0); fetch(8'd7); fetch(8'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
